alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 17 +
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter_rr_arb2.sv | 37 +++
 rtl/alu_arbiter.sv | 84 ++++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter.
// FSM state encoding and requester id type.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

  function automatic req_id_t gnt_to_id(logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of alu_arbiter.
// master = requesters/ALU/consumer side, slave = arbiter.
interface alu_arbiter_if #(
  parameter int CONTROL_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
);
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [CONTROL_WIDTH-1:0] req0_ctrl;
  logic [CONTROL_WIDTH-1:0] req1_ctrl;
  logic [DATA_WIDTH-1:0]    req0_a;
  logic [DATA_WIDTH-1:0]    req0_b;
  logic [DATA_WIDTH-1:0]    req1_a;
  logic [DATA_WIDTH-1:0]    req1_b;
  logic [CONTROL_WIDTH-1:0] alu_ctrl;
  logic [DATA_WIDTH-1:0]    alu_srca;
  logic [DATA_WIDTH-1:0]    alu_srcb;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     alu_zero;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_id;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     rsp_zero;

  modport master (
    output req_valid, req0_ctrl, req1_ctrl,
    output req0_a, req0_b, req1_a, req1_b,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_ctrl, alu_srca, alu_srcb,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req0_ctrl, req1_ctrl,
    input  req0_a, req0_b, req1_a, req1_b,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_ctrl, alu_srca, alu_srcb,
    output rsp_valid, rsp_id, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant selector; ALU_ARBITER_RR_EN selects round-robin,
// otherwise requester 0 has fixed priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
`ifdef ALU_ARBITER_RR_EN
  logic prio_q;

  // prio_q names the requester that wins a tie
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (advance) begin
      prio_q <= ~grant[1];
    end
  end
`else
  logic unused_rr;

  assign unused_rr = ^{clk, rst, advance};
  assign grant = valid[0] ? 2'b01 : {valid[1], 1'b0};
`endif
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
// Define ALU_ARBITER_RR_EN for round-robin grant (else fixed).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CONTROL_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  state_t                   state_q;
  req_id_t                  id_q;
  logic [CONTROL_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0]    a_q;
  logic [DATA_WIDTH-1:0]    b_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     zero_q;
  logic                     rsp_valid_q;
  logic [1:0]               grant;
  logic                     accept;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign accept = (state_q == IDLE) && (|grant);
  assign bus.req_ready =
    (state_q == IDLE && !rst) ? grant : 2'b00;

  assign bus.alu_ctrl  = ctrl_q;
  assign bus.alu_srca  = a_q;
  assign bus.alu_srcb  = b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_zero  = zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            id_q    <= gnt_to_id(grant);
            ctrl_q  <= grant[1] ? bus.req1_ctrl : bus.req0_ctrl;
            a_q     <= grant[1] ? bus.req1_a : bus.req0_a;
            b_q     <= grant[1] ? bus.req1_b : bus.req0_b;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          data_q      <= bus.alu_result;
          zero_q      <= bus.alu_zero;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases plus random traffic
// against a transaction-level model of grant order and results.
module tb_alu_arbiter;
  localparam int CW = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   last_gnt;

  always #5 clk = ~clk;

  alu_arbiter_if #(.CONTROL_WIDTH(CW), .DATA_WIDTH(DW)) bus ();

  alu_arbiter #(.CONTROL_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] alu_ref(
    input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (c == 3'd0) return a + b;
    if (c == 3'd1) return a - b;
    return a ^ b;
  endfunction

  always_comb begin
    bus.alu_result = alu_ref(bus.alu_ctrl, bus.alu_srca, bus.alu_srcb);
    bus.alu_zero   = (bus.alu_result == '0);
  end

  function automatic int pick(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef ALU_ARBITER_RR_EN
      return 1 - last_gnt;
`else
      return 0;
`endif
    end
    return v[0] ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_id"},    bus.rsp_id, 0);
    chk({tag, "_rsp_data"},  bus.rsp_data, 0);
    chk({tag, "_rsp_zero"},  bus.rsp_zero, 0);
    chk({tag, "_alu_ctrl"},  bus.alu_ctrl, 0);
    chk({tag, "_alu_srca"},  bus.alu_srca, 0);
    chk({tag, "_alu_srcb"},  bus.alu_srcb, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 2'b00);
  endtask

  task automatic run_op(
    input string tag, input logic [1:0] v,
    input logic [CW-1:0] c0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
    input logic [CW-1:0] c1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
    input int stall, input bit keep, input logic [DW-1:0] new_a0);
    int g;
    logic [CW-1:0] ec;
    logic [DW-1:0] ea, eb, er;
    bus.req_valid = v;
    bus.req0_ctrl = c0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_ctrl = c1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready = (stall == 0);
    g  = pick(v);
    ec = (g == 1) ? c1 : c0;
    ea = (g == 1) ? a1 : a0;
    eb = (g == 1) ? b1 : b0;
    er = alu_ref(ec, ea, eb);
    #1;
    chk({tag, "_req_ready"}, bus.req_ready, (g == 1) ? 2'b10 : 2'b01);
    tick();
    last_gnt = g;
    if (!keep) bus.req_valid = 2'b00;
    bus.req0_a = new_a0;
    bus.req0_b = $urandom;
    bus.req1_a = $urandom;
    bus.req1_b = $urandom;
    bus.req0_ctrl = CW'($urandom_range(0, 2));
    bus.req1_ctrl = CW'($urandom_range(0, 2));
    #1;
    chk({tag, "_exec_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_exec_req_ready"}, bus.req_ready, 2'b00);
    chk({tag, "_exec_alu_ctrl"},  bus.alu_ctrl, ec);
    chk({tag, "_exec_alu_srca"},  bus.alu_srca, ea);
    chk({tag, "_exec_alu_srcb"},  bus.alu_srcb, eb);
    tick();
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_bp_rsp_valid"}, bus.rsp_valid, 1);
      chk({tag, "_bp_rsp_data"},  bus.rsp_data, er);
      chk({tag, "_bp_rsp_id"},    bus.rsp_id, g);
      chk({tag, "_bp_req_ready"}, bus.req_ready, 2'b00);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    chk({tag, "_rsp_id"},    bus.rsp_id, g);
    chk({tag, "_rsp_data"},  bus.rsp_data, er);
    chk({tag, "_rsp_zero"},  bus.rsp_zero, (er == '0));
    tick();
    chk({tag, "_idle_rsp_valid"}, bus.rsp_valid, 0);
  endtask

  initial begin
    logic [1:0]    v;
    logic [CW-1:0] c0, c1;
    logic [DW-1:0] a0, b0, a1, b1;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    bus.req0_ctrl = '0; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
    bus.req1_ctrl = '0; bus.req1_a = 32'd5; bus.req1_b = 32'd6;
    last_gnt = 1;
    #12;
    chk_reset_vals("reset");
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_noreq_ready", bus.req_ready, 2'b00);
    tick();
    chk("idle_noreq_valid", bus.rsp_valid, 0);

    run_op("single_add", 2'b01, 3'd0, 32'd5, 32'd7,
           3'd0, 32'd0, 32'd0, 0, 1'b0, 32'd55);
    run_op("zero_sub", 2'b10, 3'd0, 32'd1, 32'd1,
           3'd1, 32'd9, 32'd9, 0, 1'b0, 32'd66);
    run_op("backpressure", 2'b01, 3'd1, 32'd50, 32'd8,
           3'd0, 32'd0, 32'd0, 5, 1'b0, 32'd77);
    run_op("operand_change", 2'b01, 3'd0, 32'd1, 32'd2,
           3'd0, 32'd0, 32'd0, 0, 1'b0, 32'd100);

    // abort an operation mid-EXEC
    bus.req_valid = 2'b01;
    bus.req0_ctrl = 3'd0; bus.req0_a = 32'd20; bus.req0_b = 32'd22;
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_exec_reset");
    #1;
    rst = 1'b0;
    last_gnt = 1;
    tick();
    chk("after_abort_valid", bus.rsp_valid, 0);
    tick();
    chk("after_abort_valid2", bus.rsp_valid, 0);
    chk("after_abort_ready", bus.req_ready, 2'b00);

    for (int k = 0; k < 4; k++) begin
      run_op("contention", 2'b11, 3'd0, 32'd10 + k, 32'd1,
             3'd1, 32'd40 + k, 32'd1, 0, 1'b1, $urandom);
    end
    bus.req_valid = 2'b00;

    for (int k = 0; k < 24; k++) begin
      v  = 2'($urandom_range(1, 3));
      c0 = CW'($urandom_range(0, 2));
      c1 = CW'($urandom_range(0, 2));
      a0 = $urandom; b0 = $urandom;
      a1 = $urandom; b1 = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        b0 = a0;
        b1 = a1;
      end
      run_op("random", v, c0, a0, b0, c1, a1, b1,
             $urandom_range(0, 3), 1'b0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
